// File: rtl/uart_ctrl.sv
// UART controller: TX/RX serialisers with show-ahead FIFOs, sticky line errors,
// RX watermark interrupt and optional parity, driven by a one-op-per-cycle CPU bus.
module uart_ctrl #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 4,
  parameter int PARITY   = 0,
  parameter int RX_WM    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cpu_op,
  input  logic [7:0]  cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        irq,
  output logic        tx,
  input  logic        rx
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(DIV);
  localparam int UW    = FIFO_AW + 1;

  localparam logic [CW-1:0]      DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0]      HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [UW-1:0]      DEPTH_U = UW'(DEPTH);
  localparam logic [UW-1:0]      RX_WM_U = UW'(RX_WM);
  localparam logic [UW-1:0]      USE_ONE = UW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic               PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  logic op_clr, op_pop, op_push, op_flush;

  assign op_clr   = (cpu_op == 3'b001);
  assign op_pop   = (cpu_op == 3'b010);
  assign op_push  = (cpu_op == 3'b011);
  assign op_flush = (cpu_op == 3'b100);

  // TX FIFO
  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [UW-1:0]      tx_used_q, tx_used_d;
  logic               tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_used_q == DEPTH_U);
  assign tx_empty = (tx_used_q == '0);
  assign tx_push  = op_push && !tx_full;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_used_d = tx_used_q;
    if (op_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_used_d = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
      if (tx_push && !tx_pop)      tx_used_d = tx_used_q + USE_ONE;
      else if (!tx_push && tx_pop) tx_used_d = tx_used_q - USE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= cpu_wdata;
  end

  // TX serialiser
  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_q, tx_d;
  logic            tx_par_bit;

  assign tx_par_bit = (^tx_byte_q) ^ PAR_ODD;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_byte_d  = tx_mem[tx_rptr_q];
          tx_d       = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_byte_q[0];
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            if (PARITY != 0) begin
              tx_d       = tx_par_bit;
              tx_state_d = S_PAR;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = S_STOP;
            end
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_d     = tx_byte_q[tx_bit_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_PAR: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  // RX deserialiser; rx_s3_q is the previous synchronised sample for edge detect
  state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_perr_q, rx_perr_d;
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  logic            rx_done, set_frame, set_par;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_done    = 1'b0;
    set_frame  = 1'b0;
    set_par    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_perr_d  = 1'b0;
            rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_PAR: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_perr_d  = ((^rx_shift_q) ^ rx_s2_q) != PAR_ODD;
          rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (!rx_s2_q)       set_frame = 1'b1;
          else if (rx_perr_q) set_par   = 1'b1;
          else                rx_done   = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX FIFO; a byte landing in a flush cycle goes into the freshly emptied slot 0
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d, rx_waddr;
  logic [UW-1:0]      rx_used_q, rx_used_d;
  logic               rx_full, rx_empty, rx_pop, rx_wr, set_ovr;

  assign rx_full  = (rx_used_q == DEPTH_U);
  assign rx_empty = (rx_used_q == '0);
  assign rx_pop   = op_pop && !rx_empty;
  assign rx_wr    = rx_done && (!rx_full || rx_pop || op_flush);
  assign set_ovr  = rx_done && !rx_wr;
  assign rx_waddr = op_flush ? '0 : rx_wptr_q;

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_used_d = rx_used_q;
    if (op_flush) begin
      rx_rptr_d = '0;
      rx_wptr_d = rx_wr ? PTR_ONE : '0;
      rx_used_d = rx_wr ? USE_ONE : '0;
    end else begin
      if (rx_wr)  rx_wptr_d = rx_wptr_q + PTR_ONE;
      if (rx_pop) rx_rptr_d = rx_rptr_q + PTR_ONE;
      if (rx_wr && !rx_pop)      rx_used_d = rx_used_q + USE_ONE;
      else if (!rx_wr && rx_pop) rx_used_d = rx_used_q - USE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_waddr] <= rx_shift_q;
  end

  // Sticky errors: a same-cycle detection wins over a clear
  logic frame_err_q, frame_err_d, par_err_q, par_err_d, ovr_err_q, ovr_err_d;

  always_comb begin
    frame_err_d = (frame_err_q && !op_clr) || set_frame;
    par_err_d   = (par_err_q   && !op_clr) || set_par;
    ovr_err_d   = (ovr_err_q   && !op_clr) || set_ovr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_used_q   <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_used_q   <= '0;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_perr_q   <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_used_q   <= tx_used_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_used_q   <= rx_used_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_perr_q   <= rx_perr_d;
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_byte_q  <= tx_byte_d;
    rx_shift_q <= rx_shift_d;
  end

  logic [7:0] rx_head;

  assign rx_head   = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
  assign cpu_rdata = {1'b0, par_err_q, ovr_err_q, frame_err_q,
                      tx_full, tx_empty, rx_full, rx_empty,
                      rx_head, 8'(tx_used_q), 8'(rx_used_q)};
  assign irq       = (rx_used_q >= RX_WM_U) || frame_err_q || par_err_q || ovr_err_q;
  assign tx        = tx_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: DIV=10, 4-deep FIFOs, watermark 2; a second instance
// with odd parity covers the parity path.
module tb_uart_ctrl;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cpu_op = 3'd0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic [31:0] cpu_rdata;
  logic        irq, tx_w, rx_w;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;

  logic [2:0]  cpu_op2 = 3'd0;
  logic [7:0]  cpu_wdata2 = 8'd0;
  logic [31:0] cpu_rdata2;
  logic        irq2, tx2;
  logic        rx2_drv = 1'b1;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx_sb[$];
  logic       exp_bits[$];

  always #5 clk = ~clk;

  assign rx_w = loop ? tx_w : rx_drv;

  uart_ctrl #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_AW(2), .PARITY(0), .RX_WM(2)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_op(cpu_op), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .irq(irq), .tx(tx_w), .rx(rx_w));

  uart_ctrl #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_AW(2), .PARITY(2), .RX_WM(2)) dut_par (
    .clk(clk), .rst_n(rst_n), .cpu_op(cpu_op2), .cpu_wdata(cpu_wdata2),
    .cpu_rdata(cpu_rdata2), .irq(irq2), .tx(tx2), .rx(rx2_drv));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] code, input logic [7:0] data);
    cpu_op = code;
    cpu_wdata = data;
    cyc();
    cpu_op = 3'd0;
  endtask

  task automatic line(input bit to2, input logic v);
    if (to2) rx2_drv = v;
    else     rx_drv = v;
    repeat (DIV) cyc();
  endtask

  task automatic send(input bit to2, input logic [7:0] b, input bit par_en,
                      input logic pbit, input logic stop);
    line(to2, 1'b0);
    for (int i = 0; i < 8; i++) line(to2, b[i]);
    if (par_en) line(to2, pbit);
    line(to2, stop);
    if (to2) rx2_drv = 1'b1;
    else     rx_drv = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_rdata !== 32'h0500_0000) begin failures++; $display("FAIL reset_rdata: got %h expected %h", cpu_rdata, 32'h0500_0000); end
    checks++; if (tx_w !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx_w); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (cpu_rdata2 !== 32'h0500_0000) begin failures++; $display("FAIL reset_rdata2: got %h expected %h", cpu_rdata2, 32'h0500_0000); end
    rst_n = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_tx_frame();
    logic [7:0] b = 8'h55;
    logic e;
    for (int i = 0; i < DIV; i++) exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) for (int i = 0; i < DIV; i++) exp_bits.push_back(b[k]);
    for (int i = 0; i < DIV; i++) exp_bits.push_back(1'b1);
    op(3'b011, b);
    @(negedge clk);
    checks++; if (cpu_rdata[15:8] !== 8'd1) begin failures++; $display("FAIL tx_used_after_push: got %0d expected 1", cpu_rdata[15:8]); end
    checks++; if (tx_w !== 1'b1) begin failures++; $display("FAIL tx_still_idle: got %b expected 1", tx_w); end
    @(negedge clk);
    checks++; if (cpu_rdata[15:8] !== 8'd0) begin failures++; $display("FAIL tx_used_after_pop: got %0d expected 0", cpu_rdata[15:8]); end
    for (int c = 0; exp_bits.size() > 0; c++) begin
      e = exp_bits.pop_front();
      checks++; if (tx_w !== e) begin failures++; $display("FAIL tx_bit cycle %0d: got %b expected %b", c, tx_w, e); end
      @(negedge clk);
    end
    checks++; if (tx_w !== 1'b1 || cpu_rdata[26] !== 1'b1) begin failures++; $display("FAIL tx_after_stop: tx=%b tx_empty=%b expected 1 1", tx_w, cpu_rdata[26]); end
    cyc();
  endtask

  task automatic test_loopback();
    int n = 0;
    logic [7:0] exp;
    loop = 1'b1;
    op(3'b011, 8'hA5); rx_sb.push_back(8'hA5);
    op(3'b011, 8'h3C); rx_sb.push_back(8'h3C);
    while (cpu_rdata[7:0] !== 8'd2 && n < 400) begin cyc(); n++; end
    checks++; if (n >= 400) begin failures++; $display("FAIL loop_wait: rx_used=%0d after %0d cycles, required 2", cpu_rdata[7:0], n); end
    @(negedge clk);
    exp = rx_sb.pop_front();
    checks++; if (cpu_rdata[7:0] !== 8'd2) begin failures++; $display("FAIL loop_rx_used: got %0d expected 2", cpu_rdata[7:0]); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL loop_irq_wm: got %b expected 1", irq); end
    checks++; if (cpu_rdata[23:16] !== exp) begin failures++; $display("FAIL loop_head0: got %h expected %h", cpu_rdata[23:16], exp); end
    op(3'b010, 8'h00);
    @(negedge clk);
    exp = rx_sb.pop_front();
    checks++; if (cpu_rdata[23:16] !== exp) begin failures++; $display("FAIL loop_head1: got %h expected %h", cpu_rdata[23:16], exp); end
    checks++; if (cpu_rdata[7:0] !== 8'd1) begin failures++; $display("FAIL loop_rx_used_pop: got %0d expected 1", cpu_rdata[7:0]); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL loop_irq_below_wm: got %b expected 0", irq); end
    op(3'b010, 8'h00);
    @(negedge clk);
    checks++; if (cpu_rdata[31:24] !== 8'h05) begin failures++; $display("FAIL loop_drained_flags: got %h expected 05", cpu_rdata[31:24]); end
    repeat (20) cyc();
    loop = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) rx_sb.push_back(8'(b));
      send(1'b0, 8'(b), 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    checks++; if (cpu_rdata[25] !== 1'b1) begin failures++; $display("FAIL ovr_rx_full: got %b expected 1", cpu_rdata[25]); end
    checks++; if (cpu_rdata[29] !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", cpu_rdata[29]); end
    checks++; if (cpu_rdata[7:0] !== 8'd4) begin failures++; $display("FAIL ovr_rx_used: got %0d expected 4", cpu_rdata[7:0]); end
    checks++; if (cpu_rdata[23:16] !== rx_sb[0]) begin failures++; $display("FAIL ovr_head: got %h expected %h", cpu_rdata[23:16], rx_sb[0]); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ovr_irq: got %b expected 1", irq); end
    op(3'b001, 8'h00);
    @(negedge clk);
    checks++; if (cpu_rdata[29] !== 1'b0) begin failures++; $display("FAIL ovr_cleared: got %b expected 0", cpu_rdata[29]); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ovr_irq_level: got %b expected 1", irq); end
    while (rx_sb.size() > 0) begin
      exp = rx_sb.pop_front();
      @(negedge clk);
      checks++; if (cpu_rdata[23:16] !== exp) begin failures++; $display("FAIL ovr_drain: got %h expected %h", cpu_rdata[23:16], exp); end
      op(3'b010, 8'h00);
    end
    @(negedge clk);
    checks++; if (cpu_rdata[7:0] !== 8'd0 || irq !== 1'b0) begin failures++; $display("FAIL ovr_empty: rx_used=%0d irq=%b expected 0 0", cpu_rdata[7:0], irq); end
    cyc();
  endtask

  task automatic test_line_errors();
    send(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (cpu_rdata[28] !== 1'b1) begin failures++; $display("FAIL frame_err: got %b expected 1", cpu_rdata[28]); end
    checks++; if (cpu_rdata[7:0] !== 8'd0) begin failures++; $display("FAIL frame_discard: rx_used=%0d expected 0", cpu_rdata[7:0]); end
    op(3'b001, 8'h00);
    @(negedge clk);
    checks++; if (cpu_rdata[28] !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL frame_clear: frame_err=%b irq=%b expected 0 0", cpu_rdata[28], irq); end
    send(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (cpu_rdata2[30] !== 1'b1) begin failures++; $display("FAIL parity_err: got %b expected 1", cpu_rdata2[30]); end
    checks++; if (cpu_rdata2[7:0] !== 8'd0) begin failures++; $display("FAIL parity_discard: rx_used=%0d expected 0", cpu_rdata2[7:0]); end
    rx_sb.push_back(8'h03);
    send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (cpu_rdata2[7:0] !== 8'd1) begin failures++; $display("FAIL parity_ok_used: got %0d expected 1", cpu_rdata2[7:0]); end
    checks++; if (cpu_rdata2[23:16] !== rx_sb[0]) begin failures++; $display("FAIL parity_ok_head: got %h expected %h", cpu_rdata2[23:16], rx_sb[0]); end
    void'(rx_sb.pop_front());
    cyc();
  endtask

  task automatic test_glitch();
    rx_drv = 1'b0;
    repeat (3) cyc();
    rx_drv = 1'b1;
    repeat (30) cyc();
    @(negedge clk);
    checks++; if (cpu_rdata[7:0] !== 8'd0) begin failures++; $display("FAIL glitch_stored: rx_used=%0d expected 0", cpu_rdata[7:0]); end
    checks++; if (cpu_rdata[30:28] !== 3'b000) begin failures++; $display("FAIL glitch_flags: got %b expected 000", cpu_rdata[30:28]); end
    rx_sb.push_back(8'h5A);
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (cpu_rdata[7:0] !== 8'd1 || cpu_rdata[23:16] !== rx_sb[0]) begin failures++; $display("FAIL glitch_recover: used=%0d head=%h expected 1 %h", cpu_rdata[7:0], cpu_rdata[23:16], rx_sb[0]); end
    void'(rx_sb.pop_front());
    op(3'b010, 8'h00);
  endtask

  task automatic test_flush();
    loop = 1'b1;
    op(3'b011, 8'h11); rx_sb.push_back(8'h11);
    op(3'b011, 8'h22);
    op(3'b011, 8'h33);
    op(3'b100, 8'h00);
    @(negedge clk);
    checks++; if (cpu_rdata[15:8] !== 8'd0 || cpu_rdata[26] !== 1'b1) begin failures++; $display("FAIL flush_tx_used: got %0d expected 0", cpu_rdata[15:8]); end
    repeat (300) cyc();
    @(negedge clk);
    checks++; if (cpu_rdata[7:0] !== 8'd1) begin failures++; $display("FAIL flush_rx_used: got %0d expected 1", cpu_rdata[7:0]); end
    checks++; if (cpu_rdata[23:16] !== rx_sb[0]) begin failures++; $display("FAIL flush_inflight_byte: got %h expected %h", cpu_rdata[23:16], rx_sb[0]); end
    void'(rx_sb.pop_front());
    op(3'b010, 8'h00);
    loop = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int lows = 0;
    op(3'b011, 8'hC3);
    op(3'b011, 8'h3C);
    op(3'b011, 8'h0F);
    repeat (35) cyc();
    #2;
    checks++; if (tx_w !== 1'b0) begin failures++; $display("FAIL pre_reset_bit2: got %b expected 0", tx_w); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_w !== 1'b1) begin failures++; $display("FAIL async_reset_tx: got %b expected 1", tx_w); end
    checks++; if (cpu_rdata !== 32'h0500_0000) begin failures++; $display("FAIL async_reset_rdata: got %h expected %h", cpu_rdata, 32'h0500_0000); end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_w !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin failures++; $display("FAIL post_reset_tx_quiet: low cycles=%0d expected 0", lows); end
    checks++; if (cpu_rdata !== 32'h0500_0000) begin failures++; $display("FAIL post_reset_rdata: got %h expected %h", cpu_rdata, 32'h0500_0000); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_overrun();
    test_line_errors();
    test_glitch();
    test_flush();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Single-channel UART controller with integrated TX/RX serialisers, parametrised-depth TX and RX FIFOs, sticky error flags, RX watermark interrupt and optional parity.
- Sits between the core's UART op bus and the board tx/rx pins.
- Successor to the fixed 8N1 RX/TX pair with external FIFOs. Adds:
  - configurable depth and parity
  - frame, parity and overrun detection
  - FIFO flush
  - interrupt output

Parameters:
- CLK_FREQ, 50000000: clock frequency in Hz.
- BAUD, 115200: line rate. DIV = CLK_FREQ/BAUD, integer, rounded down. DIV >= 4.
- FIFO_AW, 4: FIFO address width. Depth = 2^FIFO_AW. Legal range 1..7.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- RX_WM, 8: RX level at which irq asserts. Legal range 1..2^FIFO_AW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_op  in  3  op code, one op per cycle:
  - 000 = nop
  - 001 = clear sticky errors
  - 010 = pop RX
  - 011 = push TX
  - 100 = flush both FIFOs
  - others = nop
- cpu_wdata  in  8  byte to push on op 011.
- cpu_rdata  out  32  status word:
  - [31:24] = {0, parity_err, overrun, frame_err, tx_full, tx_empty, rx_full, rx_empty}
  - [23:16] = RX head byte (show-ahead; 0 when empty)
  - [15:8] = tx_used, zero-extended
  - [7:0] = rx_used, zero-extended
- irq  out  1  high when (rx_used >= RX_WM) or any sticky error is set.
- tx  out  1  serial out. Idle high.
- rx  in  1  serial in, asynchronous.

Behaviour:
- Reset (async, on rst_n low):
  - tx = 1 immediately.
  - Both FIFOs empty; all pointers and counts 0; sticky flags 0; irq = 0.
  - TX FSM goes to IDLE, RX FSM goes to IDLE.
  - cpu_rdata = 32'h0500_0000.
  - Reset mid-frame aborts the frame; no partial byte is stored.
- Frame format, all frames LSB first:
  - PARITY = 0: start, 8 data bits, stop.
  - PARITY != 0: start, 8 data bits, parity bit, stop.
  - Every bit lasts DIV cycles.
- cpu_rdata and irq are registered-state derived: a push or pop in cycle N is reflected in cycle N+1.
- TX FSM states: IDLE -> START -> DATA(8) -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
  - In IDLE with TX FIFO non-empty: pop the head, latch it, enter START. tx goes low the next cycle.
  - Push into an empty FIFO with TX idle at cycle N: tx falls at N+2.
  - Back-to-back frames have exactly one idle-high cycle between stop and next start.
- RX path:
  - rx passes a 2-flop synchroniser.
  - IDLE: a falling edge enters START.
  - START: sample at DIV/2. If high, treat as a glitch and return to IDLE, no flag. Otherwise sample data, parity and stop every DIV cycles.
  - Stop sampled low: set frame_err, discard byte.
  - Parity mismatch: set parity_err, discard byte.
  - Valid byte with RX FIFO full: drop byte, set overrun. Existing contents are unchanged.
- FIFO rules:
  - Push on full TX FIFO is ignored, no flag.
  - Pop on empty RX FIFO is ignored.
  - A CPU push and a TX-FSM pop in the same cycle both occur; tx_used is unchanged.
  - A CPU pop and an RX write in the same cycle both occur; rx_used is unchanged.
  - Pointers wrap modulo depth.
  - used counts range 0..2^FIFO_AW (FIFO_AW+1 bits).
- Flush (op 100):
  - Both FIFOs' pointers and counts reset in the next cycle.
  - A TX frame in flight completes with its latched byte.
  - An RX frame in flight continues and is stored normally after the flush.
- Clear errors (op 001) clears all three sticky flags. If a new error is detected in the same cycle, that flag ends set.
- An op with invalid operands has no side effect.

Test Plan:
Bench parameters: CLK_FREQ=1000000, BAUD=100000 (DIV=10), FIFO_AW=2, RX_WM=2, PARITY=0 unless stated.
1. Push 0x55 at cycle N.
   - tx_used=1 at N+1.
   - tx low over N+2..N+11, then bits 1,0,1,0,1,0,1,0 (10 cycles each), then stop high.
   - tx_used=0 after the FSM pops.
2. Loop tx to rx; push 0xA5 then 0x3C.
   - After both frames: rx_used=2, irq=1, cpu_rdata[23:16]=0xA5.
   - Pop: next cycle [23:16]=0x3C, rx_used=1, irq=0.
3. Send 5 valid bytes 0x01..0x05 on rx.
   - rx_full=1, overrun=1, rx_used=4, head=0x01, irq=1.
   - op 001: overrun=0; irq stays 1 (level 4 >= 2).
4. Drive a frame with a low stop bit.
   - frame_err=1, rx_used unchanged.
   - With PARITY=2, send 0x03 with parity bit 0: parity_err=1, byte discarded.
5. Pulse rx low for 3 cycles.
   - No byte stored, no flag set, RX FSM back in IDLE.
6. Push 3 bytes, deassert rst_n mid-data-bit.
   - tx=1 in the same cycle, cpu_rdata=32'h0500_0000.
   - After release: no residual transmission.
